// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one shift-add or restoring-divide step per clock,
// with a Start/Busy/Done handshake and a registered Result/Zero pair.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            Start,
  input  logic [2:0]      MulDivOp,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  output logic            Busy,
  output logic            Done,
  output logic [XLEN-1:0] Result,
  output logic            Zero,
  output logic [1:0]      dbg_state
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST_STEP = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Handshake: Start is taken on any edge where the unit is not in RUN; Busy covers
  // exactly the RUN cycles and Done is a one-cycle pulse when Result/Zero are fresh.

  state_t              state;
  logic [2:0]          op_q;
  logic [CW-1:0]       cnt;
  logic [2*XLEN-1:0]   acc;
  logic [XLEN-1:0]     opnd;
  logic                neg_q;
  logic                neg_r;

  logic                a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                div_zero, div_ovf, special;
  logic [XLEN-1:0]     special_res;

  logic [XLEN:0]       mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0]   acc_nxt, prod_s;
  logic [XLEN-1:0]     quo, rem, fin_res;

  assign dbg_state = state;

  // Operand decode and special-case detection on the raw inputs at accept time.
  always_comb begin
    a_signed    = (MulDivOp == 3'b001) || (MulDivOp == 3'b010) ||
                  (MulDivOp == 3'b100) || (MulDivOp == 3'b110);
    b_signed    = (MulDivOp == 3'b001) || (MulDivOp == 3'b100) || (MulDivOp == 3'b110);
    a_neg       = a_signed && SrcA[XLEN-1];
    b_neg       = b_signed && SrcB[XLEN-1];
    a_mag       = a_neg ? (~SrcA + 1'b1) : SrcA;
    b_mag       = b_neg ? (~SrcB + 1'b1) : SrcB;
    div_zero    = MulDivOp[2] && (SrcB == '0);
    div_ovf     = MulDivOp[2] && !MulDivOp[0] &&
                  (SrcA == {1'b1, {(XLEN-1){1'b0}}}) && (SrcB == '1);
    special     = div_zero || div_ovf;
    special_res = '0;
    if (div_zero) special_res = MulDivOp[1] ? SrcA : '1;
    else          special_res = MulDivOp[1] ? '0 : SrcA;
  end

  // One iteration. Multiply keeps {partial_hi, multiplier_lo}; divide keeps {remainder, dividend/quotient}.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
    acc_nxt   = {mul_sum, acc[XLEN-1:1]};
    if (op_q[2]) begin
      if (!div_diff[XLEN]) acc_nxt = {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else                 acc_nxt = {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix-up applied to the value produced by the final iteration.
  always_comb begin
    prod_s  = neg_q ? (~acc_nxt + 1'b1) : acc_nxt;
    quo     = acc_nxt[XLEN-1:0];
    rem     = acc_nxt[2*XLEN-1:XLEN];
    fin_res = '0;
    case (op_q)
      3'b000:                 fin_res = prod_s[XLEN-1:0];
      3'b001, 3'b010, 3'b011: fin_res = prod_s[2*XLEN-1:XLEN];
      3'b100, 3'b101:         fin_res = neg_q ? (~quo + 1'b1) : quo;
      default:                fin_res = neg_r ? (~rem + 1'b1) : rem;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      op_q   <= '0;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
      Result <= '0;
      Zero   <= 1'b1;
    end else begin
      case (state)
        S_RUN: begin
          acc <= acc_nxt;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            state  <= S_DONE;
            Busy   <= 1'b0;
            Done   <= 1'b1;
            Result <= fin_res;
            Zero   <= (fin_res == '0);
          end
        end
        default: begin
          if (Start) begin
            op_q  <= MulDivOp;
            cnt   <= '0;
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
            if (MulDivOp[2]) begin
              acc  <= {{XLEN{1'b0}}, a_mag};
              opnd <= b_mag;
            end else begin
              acc  <= {{XLEN{1'b0}}, b_mag};
              opnd <= a_mag;
            end
            if (special) begin
              state  <= S_DONE;
              Busy   <= 1'b0;
              Done   <= 1'b1;
              Result <= special_res;
              Zero   <= (special_res == '0);
            end else begin
              state <= S_RUN;
              Busy  <= 1'b1;
              Done  <= 1'b0;
            end
          end else begin
            state <= S_IDLE;
            Busy  <= 1'b0;
            Done  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: XLEN=32 and XLEN=8 instances, expected results queued at issue
// and compared when Done pulses; latency and Busy counts checked per operation.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start32 = 1'b0;
  logic        start8 = 1'b0;
  logic [2:0]  op_i = '0;
  logic [31:0] a_i = '0;
  logic [31:0] b_i = '0;

  logic        busy32, done32, zero32;
  logic [31:0] result32;
  logic [1:0]  state32;
  logic        busy8, done8, zero8;
  logic [7:0]  result8;
  logic [1:0]  state8;

  logic [31:0] exp_q32[$];
  logic [7:0]  exp_q8[$];
  logic [31:0] e32;
  logic [7:0]  e8;

  int total = 0;
  int bad   = 0;

  // clock / reset
  always #5 clk = ~clk;

  muldiv_unit #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .Start(start32), .MulDivOp(op_i),
    .SrcA(a_i), .SrcB(b_i), .Busy(busy32), .Done(done32),
    .Result(result32), .Zero(zero32), .dbg_state(state32)
  );

  muldiv_unit #(.XLEN(8)) dut8 (
    .clk(clk), .reset(reset), .Start(start8), .MulDivOp(op_i),
    .SrcA(a_i[7:0]), .SrcB(b_i[7:0]), .Busy(busy8), .Done(done8),
    .Result(result8), .Zero(zero8), .dbg_state(state8)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] ref32(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    logic [31:0] r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    r  = '0;
    case (op)
      3'b000: begin p = ua * ub; r = p[31:0];  end
      3'b001: begin p = sa * sb; r = p[63:32]; end
      3'b010: begin p = sa * ub; r = p[63:32]; end
      3'b011: begin p = ua * ub; r = p[63:32]; end
      3'b100: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else begin p = sa / sb; r = p[31:0]; end
      end
      3'b101: begin
        if (b == 32'd0) r = 32'hFFFF_FFFF;
        else begin p = ua / ub; r = p[31:0]; end
      end
      3'b110: begin
        if (b == 32'd0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
        else begin p = sa % sb; r = p[31:0]; end
      end
      default: begin
        if (b == 32'd0) r = a;
        else begin p = ua % ub; r = p[31:0]; end
      end
    endcase
    return r;
  endfunction

  function automatic int lat32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 32'd0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
      return 1;
    return 33;
  endfunction

  // scoreboard: every Done pops one expected result
  always @(negedge clk) begin
    if (done32) begin
      if (exp_q32.size() == 0) check_val("done32_unexpected", done32, 0);
      else begin
        e32 = exp_q32.pop_front();
        check_val("res32", result32, e32);
        check_val("zero32", zero32, e32 == 32'd0);
        check_val("busy_done32", busy32, 0);
      end
    end
    if (done8) begin
      if (exp_q8.size() == 0) check_val("done8_unexpected", done8, 0);
      else begin
        e8 = exp_q8.pop_front();
        check_val("res8", result8, e8);
        check_val("zero8", zero8, e8 == 8'd0);
        check_val("busy_done8", busy8, 0);
      end
    end
  end

  // driver: present one request for one edge, then scramble the inputs
  task automatic start_op(input bit is8, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] want);
    @(negedge clk);
    op_i = op;
    a_i  = a;
    b_i  = b;
    if (is8) begin
      start8 = 1'b1;
      exp_q8.push_back(want[7:0]);
    end else begin
      start32 = 1'b1;
      exp_q32.push_back(want);
    end
    @(negedge clk);
    start8  = 1'b0;
    start32 = 1'b0;
    op_i    = 3'($urandom_range(0, 7));
    a_i     = $urandom;
    b_i     = $urandom;
  endtask

  // entered in output window t+lat0; returns in the Done window
  task automatic wait_done(input bit is8, input int lat0, input int exp_lat, input string tag);
    int lat;
    int busy_n;
    lat    = lat0;
    busy_n = 0;
    while (!(is8 ? done8 : done32) && lat < 100) begin
      if (is8 ? busy8 : busy32) busy_n++;
      @(negedge clk);
      lat++;
    end
    check_val({tag, "_lat"}, lat, exp_lat);
    check_val({tag, "_busy"}, busy_n, exp_lat - lat0);
  endtask

  task automatic run_op(input bit is8, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] want, input int exp_lat,
                        input string tag);
    start_op(is8, op, a, b, want);
    wait_done(is8, 1, exp_lat, tag);
    @(negedge clk);
    check_val({tag, "_pulse"}, is8 ? done8 : done32, 0);
    check_val({tag, "_idle"}, is8 ? state8 : state32, 0);
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_val("rst_busy", busy32, 0);
    check_val("rst_done", done32, 0);
    check_val("rst_result", result32, 0);
    check_val("rst_zero", zero32, 1);
    check_val("rst_state", state32, 0);
    check_val("rst_result8", result8, 0);
    reset = 1'b0;

    run_op(0, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul");
    run_op(0, 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh");
    run_op(0, 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu");
    run_op(0, 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu");
    run_op(0, 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div");
    run_op(0, 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem");
    run_op(0, 3'b101, 32'd100, 32'd7, 32'd14, 33, "divu");
    run_op(0, 3'b111, 32'd100, 32'd7, 32'd2, 33, "remu");
    run_op(0, 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div0");
    run_op(0, 3'b111, 32'd5, 32'd0, 32'd5, 1, "remu0");
    run_op(0, 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run_op(0, 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem_ovf");

    // a second Start while in RUN must be ignored
    start_op(0, 3'b101, 32'd100, 32'd7, 32'd14);
    repeat (4) @(negedge clk);
    op_i = 3'b000; a_i = 32'd5; b_i = 32'd5; start32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    wait_done(0, 6, 33, "midrun");
    @(negedge clk);

    // Start held in DONE: back-to-back accept
    start_op(0, 3'b110, 32'd100, 32'd7, 32'd2);
    wait_done(0, 1, 33, "b2b_first");
    op_i = 3'b000; a_i = 32'd6; b_i = 32'd7; start32 = 1'b1;
    exp_q32.push_back(32'd42);
    @(negedge clk);
    start32 = 1'b0;
    check_val("b2b_done_fell", done32, 0);
    check_val("b2b_busy", busy32, 1);
    wait_done(0, 1, 33, "b2b_second");
    @(negedge clk);

    // reset in RUN cycle 10 discards the operation
    start_op(0, 3'b000, 32'h0001_2345, 32'h0000_0111, ref32(3'b000, 32'h0001_2345, 32'h0000_0111));
    repeat (9) @(negedge clk);
    check_val("run10_busy", busy32, 1);
    reset = 1'b1;
    exp_q32.delete();
    @(negedge clk);
    check_val("midrst_busy", busy32, 0);
    check_val("midrst_done", done32, 0);
    check_val("midrst_result", result32, 0);
    check_val("midrst_zero", zero32, 1);
    check_val("midrst_state", state32, 0);
    reset = 1'b0;
    run_op(0, 3'b000, 32'd3, 32'd4, 32'd12, 33, "mul_after_rst");

    // XLEN = 8 instance
    run_op(1, 3'b011, 32'hFF, 32'hFF, 32'hFE, 9, "mulhu8");
    run_op(1, 3'b100, 32'h80, 32'hFF, 32'h80, 1, "div8_ovf");
    run_op(1, 3'b101, 32'd200, 32'd7, 32'd28, 9, "divu8");
    run_op(1, 3'b110, 32'hF9, 32'd2, 32'hFF, 9, "rem8");

    // random operations against the reference model
    for (int i = 0; i < 12; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      case ($urandom_range(0, 5))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(1, 9));
        2:       rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        default: rb = $urandom;
      endcase
      run_op(0, rop, ra, rb, ref32(rop, ra, rb), lat32(rop, ra, rb), "rand");
    end

    check_val("q32_empty", exp_q32.size(), 0);
    check_val("q8_empty", exp_q8.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
